// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared-ALU / shared-memory datapath.
// Sequences each instruction over several clocks, stalls on mem_ready, counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_FETCH = 4'd1,
    S_DEC   = 4'd2,
    S_MADDR = 4'd3,
    S_MRD   = 4'd4,
    S_MWB   = 4'd5,
    S_MWR   = 4'd6,
    S_REXE  = 4'd7,
    S_RWB   = 4'd8,
    S_BR    = 4'd9,
    S_IEXE  = 4'd10,
    S_IWB   = 4'd11,
    S_JMP   = 4'd12
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] retired_r;
  logic             illegal_r;
  logic             retire_s;
  logic             illegal_s;

  // funct and zero are consumed by the ALU control and PC-enable logic outside this block.
  logic unused_s;
  assign unused_s = ^{funct, zero};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_RST;
    end else begin
      state_r <= next_s;
    end
  end

  // Retired-instruction counter and sticky illegal-opcode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_W{1'b0}};
      illegal_r <= 1'b0;
    end else begin
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
      if (illegal_s) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  // Next-state and control decode from the registered state and mem_ready.
  always_comb begin
    next_s        = S_FETCH;
    retire_s      = 1'b0;
    illegal_s     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_r)
      S_RST: begin
        next_s = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_s = S_DEC;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DEC: begin
        // Speculative branch target PC+1+imm lands in ALUOut.
        alu_src_b = 2'b10;
        case (opcode)
          OP_LW, OP_SW: next_s = S_MADDR;
          OP_R:         next_s = S_REXE;
          OP_BEQ:       next_s = S_BR;
          OP_ADDI:      next_s = S_IEXE;
          OP_J:         next_s = S_JMP;
          default: begin
            next_s    = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_SW) begin
          next_s = S_MWR;
        end else begin
          next_s = S_MRD;
        end
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          next_s = S_MWB;
        end else begin
          next_s = S_MRD;
        end
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_s   = 1'b1;
        next_s     = S_FETCH;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          next_s   = S_FETCH;
          retire_s = 1'b1;
        end else begin
          next_s = S_MWR;
        end
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        next_s    = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_s  = 1'b1;
        next_s    = S_FETCH;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire_s      = 1'b1;
        next_s        = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next_s    = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire_s  = 1'b1;
        next_s    = S_FETCH;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire_s  = 1'b1;
        next_s    = S_FETCH;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

  assign state_o    = state_r;
  assign retired    = retired_r;
  assign illegal_op = illegal_r;

endmodule
